// File: rtl/fb_rect_writer.sv
// Filled-rectangle writer for the double-buffered framebuffer, two pixels per clock.
// Optional back-buffer clear after each swap is enabled by defining FB_WRITER_CLEAR_EN.
module fb_rect_writer #(
  parameter int unsigned H_RES       = 640,
  parameter int unsigned V_RES       = 480,
  parameter logic [3:0]  CLEAR_COLOR = 4'h0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        vsync,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [9:0]  cmd_x,
  input  logic [8:0]  cmd_y,
  input  logic [9:0]  cmd_w,
  input  logic [8:0]  cmd_h,
  input  logic [3:0]  cmd_color,
  output logic [18:0] addr_wr1,
  output logic [18:0] addr_wr2,
  output logic [3:0]  data_wr1,
  output logic [3:0]  data_wr2,
  output logic        wr1_en,
  output logic        wr2_en,
  output logic        busy,
  output logic        frame_overrun
);

  localparam int unsigned AW = 19;
  localparam int unsigned XW = 11;
  localparam int unsigned YW = 10;

`ifdef FB_WRITER_CLEAR_EN
  localparam int unsigned KW = AW - 1;
  localparam logic [KW-1:0] LAST_K = KW'(H_RES * V_RES / 2 - 1);
  typedef enum logic [1:0] {IDLE, DRAW, CLEAR} state_t;
`else
  typedef enum logic [1:0] {IDLE, DRAW} state_t;
`endif

  state_t        state_q, state_d;
  logic          vs_q, fall_q, fall_d;
  logic [XW-1:0] col_q, col_d, x_start_q, x_start_d, x_end_q, x_end_d;
  logic [YW-1:0] row_q, row_d, y_end_q, y_end_d;
  logic [AW-1:0] row_base_q, row_base_d;
  logic [3:0]    color_q, color_d;
  logic          clear_pending_q, clear_pending_d;
`ifdef FB_WRITER_CLEAR_EN
  logic [KW-1:0] clr_k_q, clr_k_d;
`endif

  logic          cmd_ready_d, busy_d, ovr_d, wr1_d, wr2_d;
  logic [AW-1:0] addr1_d, addr2_d;
  logic [3:0]    data1_d, data2_d;

  logic [XW-1:0] sum_x, clip_x;
  logic [YW-1:0] sum_y, clip_y;
  logic          empty_cmd, emit_draw, emit_clear;

  // Clip the incoming rectangle against the screen edges
  always_comb begin
    sum_x     = XW'(cmd_x) + XW'(cmd_w);
    sum_y     = YW'(cmd_y) + YW'(cmd_h);
    clip_x    = (sum_x > XW'(H_RES)) ? XW'(H_RES) : sum_x;
    clip_y    = (sum_y > YW'(V_RES)) ? YW'(V_RES) : sum_y;
    empty_cmd = (cmd_w == 10'd0) || (cmd_h == 9'd0) ||
                (XW'(cmd_x) >= XW'(H_RES)) || (YW'(cmd_y) >= YW'(V_RES));
  end

  // Next-state and next-output logic
  always_comb begin
    state_d         = state_q;
    col_d           = col_q;
    row_d           = row_q;
    row_base_d      = row_base_q;
    x_start_d       = x_start_q;
    x_end_d         = x_end_q;
    y_end_d         = y_end_q;
    color_d         = color_q;
    clear_pending_d = clear_pending_q;
`ifdef FB_WRITER_CLEAR_EN
    clr_k_d         = clr_k_q;
`endif
    fall_d     = vs_q & ~vsync;
    ovr_d      = fall_q & (state_q != IDLE);
    emit_draw  = 1'b0;
    emit_clear = 1'b0;
    addr1_d    = '0;
    addr2_d    = '0;
    data1_d    = '0;
    data2_d    = '0;
    wr1_d      = 1'b0;
    wr2_d      = 1'b0;

    case (state_q)
      IDLE: begin
`ifdef FB_WRITER_CLEAR_EN
        if (fall_q) begin
          state_d    = CLEAR;
          clr_k_d    = '0;
          emit_clear = 1'b1;
        end else
`endif
        if (cmd_valid && cmd_ready && !empty_cmd) begin
          state_d    = DRAW;
          col_d      = XW'(cmd_x);
          row_d      = YW'(cmd_y);
          row_base_d = AW'(cmd_y) * AW'(H_RES);
          x_start_d  = XW'(cmd_x);
          x_end_d    = clip_x;
          y_end_d    = clip_y;
          color_d    = cmd_color;
          emit_draw  = 1'b1;
        end
      end
      DRAW: begin
`ifdef FB_WRITER_CLEAR_EN
        if (fall_q) clear_pending_d = 1'b1;
`endif
        if (col_q + XW'(2) < x_end_q) begin
          col_d     = col_q + XW'(2);
          emit_draw = 1'b1;
        end else if (row_q + YW'(1) != y_end_q) begin
          col_d      = x_start_q;
          row_d      = row_q + YW'(1);
          row_base_d = row_base_q + AW'(H_RES);
          emit_draw  = 1'b1;
        end else begin
          state_d = IDLE;
`ifdef FB_WRITER_CLEAR_EN
          // A swap seen during the draw chains straight into the clear
          if (clear_pending_q || fall_q) begin
            state_d         = CLEAR;
            clr_k_d         = '0;
            clear_pending_d = 1'b0;
            emit_clear      = 1'b1;
          end
`endif
        end
      end
`ifdef FB_WRITER_CLEAR_EN
      CLEAR: begin
        if (fall_q) begin
          clr_k_d    = '0;
          emit_clear = 1'b1;
        end else if (clr_k_q == LAST_K) begin
          state_d = IDLE;
        end else begin
          clr_k_d    = clr_k_q + KW'(1);
          emit_clear = 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    if (emit_draw) begin
      addr1_d = row_base_d + AW'(col_d);
      wr1_d   = 1'b1;
      data1_d = color_d;
      if (col_d + XW'(1) < x_end_d) begin
        addr2_d = addr1_d + AW'(1);
        wr2_d   = 1'b1;
        data2_d = color_d;
      end
    end
`ifdef FB_WRITER_CLEAR_EN
    if (emit_clear) begin
      addr1_d = {clr_k_d, 1'b0};
      addr2_d = {clr_k_d, 1'b1};
      data1_d = CLEAR_COLOR;
      data2_d = CLEAR_COLOR;
      wr1_d   = 1'b1;
      wr2_d   = 1'b1;
    end
`endif
    busy_d      = emit_draw | emit_clear;
    cmd_ready_d = (state_d == IDLE) & ~fall_d & ~clear_pending_d;
  end

  // State, datapath and registered outputs
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q         <= IDLE;
      vs_q            <= 1'b0;
      fall_q          <= 1'b0;
      col_q           <= '0;
      row_q           <= '0;
      row_base_q      <= '0;
      x_start_q       <= '0;
      x_end_q         <= '0;
      y_end_q         <= '0;
      color_q         <= '0;
      clear_pending_q <= 1'b0;
`ifdef FB_WRITER_CLEAR_EN
      clr_k_q         <= '0;
`endif
      cmd_ready       <= 1'b0;
      busy            <= 1'b0;
      frame_overrun   <= 1'b0;
      addr_wr1        <= '0;
      addr_wr2        <= '0;
      data_wr1        <= '0;
      data_wr2        <= '0;
      wr1_en          <= 1'b0;
      wr2_en          <= 1'b0;
    end else begin
      state_q         <= state_d;
      vs_q            <= vsync;
      fall_q          <= fall_d;
      col_q           <= col_d;
      row_q           <= row_d;
      row_base_q      <= row_base_d;
      x_start_q       <= x_start_d;
      x_end_q         <= x_end_d;
      y_end_q         <= y_end_d;
      color_q         <= color_d;
      clear_pending_q <= clear_pending_d;
`ifdef FB_WRITER_CLEAR_EN
      clr_k_q         <= clr_k_d;
`endif
      cmd_ready       <= cmd_ready_d;
      busy            <= busy_d;
      frame_overrun   <= ovr_d;
      addr_wr1        <= addr1_d;
      addr_wr2        <= addr2_d;
      data_wr1        <= data1_d;
      data_wr2        <= data2_d;
      wr1_en          <= wr1_d;
      wr2_en          <= wr2_d;
    end
  end

endmodule

// File: tb/tb_fb_rect_writer.sv
// Directed bench for fb_rect_writer (default build): reset, draw, clipping, empty commands, overrun.
module tb_fb_rect_writer;

  logic        clock = 1'b0;
  logic        reset;
  logic        vsync;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [9:0]  cmd_x;
  logic [8:0]  cmd_y;
  logic [9:0]  cmd_w;
  logic [8:0]  cmd_h;
  logic [3:0]  cmd_color;
  logic [18:0] addr_wr1, addr_wr2;
  logic [3:0]  data_wr1, data_wr2;
  logic        wr1_en, wr2_en, busy, frame_overrun;

  int vectors = 0;
  int miscompares = 0;

  fb_rect_writer dut (
    .clock(clock), .reset(reset), .vsync(vsync),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h), .cmd_color(cmd_color),
    .addr_wr1(addr_wr1), .addr_wr2(addr_wr2), .data_wr1(data_wr1), .data_wr2(data_wr2),
    .wr1_en(wr1_en), .wr2_en(wr2_en), .busy(busy), .frame_overrun(frame_overrun)
  );

  always #5 clock = ~clock;

  // Output vector: {cmd_ready, busy, wr1_en, wr2_en, addr1, addr2, data1, data2, frame_overrun}
  function automatic logic [50:0] pk(input logic rdy, input logic bsy, input logic e1,
                                     input logic e2, input logic [18:0] a1, input logic [18:0] a2,
                                     input logic [3:0] d1, input logic [3:0] d2, input logic ov);
    return {rdy, bsy, e1, e2, a1, a2, d1, d2, ov};
  endfunction

  function automatic logic [50:0] pair(input logic [18:0] a1, input logic e2,
                                       input logic [3:0] c, input logic ov);
    return pk(1'b0, 1'b1, 1'b1, e2, a1, e2 ? a1 + 19'd1 : 19'd0, c, e2 ? c : 4'd0, ov);
  endfunction

  function automatic logic [50:0] idle_v();
    return pk(1'b1, 1'b0, 1'b0, 1'b0, 19'd0, 19'd0, 4'd0, 4'd0, 1'b0);
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [50:0] expv);
    logic [50:0] obs;
    obs = pk(cmd_ready, busy, wr1_en, wr2_en, addr_wr1, addr_wr2, data_wr1, data_wr2, frame_overrun);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic send(input int x, input int y, input int w, input int h, input int c);
    cmd_x     = 10'(x);
    cmd_y     = 9'(y);
    cmd_w     = 10'(w);
    cmd_h     = 9'(h);
    cmd_color = 4'(c);
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b0; vsync = 1'b0; cmd_valid = 1'b1;
    cmd_x = 10'd10; cmd_y = 9'd2; cmd_w = 10'd5; cmd_h = 9'd2; cmd_color = 4'd7;

    // Reset held with a command offered: nothing moves
    for (int i = 0; i < 5; i++) begin
      step();
      chk("reset_hold", '0);
    end
    reset = 1'b1; cmd_valid = 1'b0;
    step();
    chk("ready_after_reset", idle_v());

    // Basic 5x2 rectangle at (10,2)
    send(10, 2, 5, 2, 7);
    chk("a_p0", pair(19'd1290, 1'b1, 4'd7, 1'b0)); step();
    chk("a_p1", pair(19'd1292, 1'b1, 4'd7, 1'b0)); step();
    chk("a_p2", pair(19'd1294, 1'b0, 4'd7, 1'b0)); step();
    chk("a_p3", pair(19'd1930, 1'b1, 4'd7, 1'b0)); step();
    chk("a_p4", pair(19'd1932, 1'b1, 4'd7, 1'b0)); step();
    chk("a_p5", pair(19'd1934, 1'b0, 4'd7, 1'b0)); step();
    chk("a_done", idle_v());

    // Bottom-right corner, clipped to 4x1
    send(636, 479, 10, 5, 3);
    chk("clip_p0", pair(19'd307196, 1'b1, 4'd3, 1'b0)); step();
    chk("clip_p1", pair(19'd307198, 1'b1, 4'd3, 1'b0)); step();
    chk("clip_done", idle_v());

    // Empty commands, then a single pixel accepted back-to-back
    send(5, 5, 0, 3, 9);
    chk("w0_idle", idle_v());
    send(640, 5, 4, 1, 9);
    chk("x640_idle", idle_v());
    send(0, 0, 1, 1, 5);
    chk("pix_p0", pair(19'd0, 1'b0, 4'd5, 1'b0)); step();
    chk("pix_done", idle_v());

    // Swap during a draw: single-cycle overrun pulse, writes unchanged
    vsync = 1'b1;
    step();
    chk("vs_high_idle", idle_v());
    send(10, 2, 5, 2, 7);
    chk("ov_p0", pair(19'd1290, 1'b1, 4'd7, 1'b0));
    vsync = 1'b0; step();
    chk("ov_p1", pair(19'd1292, 1'b1, 4'd7, 1'b0)); step();
    chk("ov_p2", pair(19'd1294, 1'b0, 4'd7, 1'b1)); step();
    chk("ov_p3", pair(19'd1930, 1'b1, 4'd7, 1'b0)); step();
    chk("ov_p4", pair(19'd1932, 1'b1, 4'd7, 1'b0)); step();
    chk("ov_p5", pair(19'd1934, 1'b0, 4'd7, 1'b0)); step();
    chk("ov_done", idle_v());

    // Swap while idle: ready drops for one cycle, no overrun
    vsync = 1'b1; step();
    vsync = 1'b0; step();
    chk("idle_fall", '0); step();
    chk("idle_fall_after", idle_v());

    // Reset mid-draw abandons the rectangle
    send(10, 2, 5, 2, 7);
    chk("rst_p0", pair(19'd1290, 1'b1, 4'd7, 1'b0)); step();
    chk("rst_p1", pair(19'd1292, 1'b1, 4'd7, 1'b0));
    reset = 1'b0; step();
    chk("rst_mid", '0);
    reset = 1'b1; step();
    chk("rst_release", idle_v()); step();
    chk("rst_stays_idle", idle_v());

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fb_rect_writer.md
# fb_rect_writer

Write-side producer for the double-buffered framebuffer: accepts filled-rectangle draw commands over a valid/ready handshake and streams 4-bit pixels into the framebuffer's two write ports (`addr_wr1/2`, `data_wr1/2`, `wr1_en/2_en`), two horizontally adjacent pixels per clock. It tracks the framebuffer's buffer swap on falling `vsync` and flags commands that straddle a swap. An optional mode clears the back buffer after each swap.

## Interface
- `H_RES`, 640: line width in pixels; address stride per row.
- `V_RES`, 480: number of lines; `H_RES*V_RES` must fit in 19 bits.
- `CLEAR_COLOR`, 4'h0: fill value used by the clear feature.

- `clock`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `vsync`  in  1  same signal the framebuffer uses to swap buffers.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  command accepted on a rising edge where `cmd_valid & cmd_ready`.
- `cmd_x`  in  10  left column. `cmd_y`  in  9  top row.
- `cmd_w`  in  10  width. `cmd_h`  in  9  height. `cmd_color`  in  4  fill value.
- `addr_wr1`, `addr_wr2`  out  19  write addresses (port 1 even offset, port 2 odd offset).
- `data_wr1`, `data_wr2`  out  4  write data.
- `wr1_en`, `wr2_en`  out  1  write strobes.
- `busy`  out  1  high while DRAW or CLEAR writes are being emitted.
- `frame_overrun`  out  1  one-cycle pulse: swap occurred while not IDLE.

## Operation
- States: IDLE, DRAW, CLEAR (CLEAR only with the macro). Reset → IDLE.
- Swap detection: `vsync` is registered into `vs_q`; `fall = vs_q & ~vsync`, registered as `fall_q`.
- `cmd_ready = reset & (state == IDLE) & ~fall_q & ~clear_pending`.
- On accept: clip `x_end = min(x+w, H_RES)` and `y_end = min(y+h, V_RES)`, using 11-bit and 10-bit sums. If `w==0`, `h==0`, `x>=H_RES` or `y>=V_RES`: no writes, stay IDLE, `cmd_ready` stays high.
- Otherwise go to DRAW with `col=x`, `row=y`, `row_base=y*H_RES`, computed incrementally or with a one-time multiply.
- DRAW, per cycle:
  - `addr_wr1 = row_base+col`, `wr1_en=1`.
  - `addr_wr2 = addr_wr1+1`, `wr2_en = (col+1 < x_end)`.
  - Both data outputs = latched `cmd_color`.
  - `col += 2`. When `col+2 >= x_end`: `col=x`, `row_base += H_RES`, `row += 1`. When `row+1 == y_end`, the last row finishes and the FSM returns to IDLE.
- When `wr2_en` is 0, `addr_wr2` and `data_wr2` are don't-care; they are driven 0.
- `fall_q` while state ≠ IDLE: `frame_overrun` pulses for 1 cycle and the current operation runs to completion unchanged.
- Outputs not writing: `wr*_en=0`, addr/data = 0.

## Timing
- All outputs are registered. Reset values: every output 0, including `cmd_ready`, while `reset` is low. `cmd_ready` is 1 in the first cycle after release.
- Command accepted at edge N: write pair k is driven during cycle N+1+k. `busy` is high exactly for those cycles.
- Write cycles = `h' * ceil(w'/2)`, where `w'` and `h'` are the clipped width and height.
- `cmd_ready` rises in the cycle after the last write pair.
- `frame_overrun` is asserted in the cycle after `fall_q`.
- `reset` low mid-DRAW/CLEAR: the operation is abandoned the next edge and all outputs are 0. No partial state is retained.

## Configuration
- `FB_WRITER_CLEAR_EN` defined, `fall_q` in IDLE:
  - Enter CLEAR and write `CLEAR_COLOR` to addresses 2k and 2k+1 for k = 0 … `H_RES*V_RES/2 - 1`: 153600 cycles, both strobes high.
  - Return to IDLE afterwards.
- `fall_q` in DRAW sets `clear_pending`; CLEAR starts immediately after DRAW ends, and `frame_overrun` still pulses.
- `fall_q` during CLEAR: the clear restarts at address 0, and `frame_overrun` pulses.
- Undefined: no CLEAR state and no `clear_pending`; `fall_q` affects only `frame_overrun`.

## Test plan
- Reset held low 5 cycles with `cmd_valid=1` → all outputs 0 and no accept; after release `cmd_ready=1` next cycle.
- Cmd x=10, y=2, w=5, h=2, color=7 → pairs (1290/1291), (1292/1293), (1294, wr2_en=0), (1930/1931), (1932/1933), (1934, wr2_en=0), data 7; `busy` high 6 cycles; `cmd_ready` back in cycle 7.
- Cmd x=636, y=479, w=10, h=5 → clipped to pairs (307196/307197), (307198/307199); 2 cycles; no address ≥307200.
- Cmd w=0 (and separately x=640) → accepted, zero writes, `busy` stays 0, second command accepted the next cycle.
- `vsync` 1→0 during the previous 6-cycle draw → `frame_overrun` single-cycle pulse; write sequence identical to the undisturbed case.
- With `FB_WRITER_CLEAR_EN`, `vsync` falls in IDLE → 153600 write cycles, first pair 0/1, last pair 307198/307199, data 0, `cmd_ready` low throughout, high the cycle after.
